// File: rtl/gj_axis_frac_baud_gen.sv
// Fractional baud tick generator: oversample, bit and mid-bit ticks from an integer+fraction divisor,
// with shadowed runtime reconfiguration, enable and start-bit phase realignment.
module gj_axis_frac_baud_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR_LOG2     = 4,
    parameter int DEF_DIV_INT  = 16,
    parameter int DEF_DIV_FRAC = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                restart_i,
    input  logic                cfg_load_i,
    input  logic [DIV_W-1:0]    cfg_div_int_i,
    input  logic [FRAC_W-1:0]   cfg_div_frac_i,
    output logic                clk_enX16_o,
    output logic                clk_en_o,
    output logic                mid_en_o,
    output logic [OSR_LOG2-1:0] os_phase_o,
    output logic                cfg_pend_o,
    output logic                cfg_err_o
);

    localparam logic [OSR_LOG2-1:0] PHASE_LAST = OSR_LOG2'((2 ** OSR_LOG2) - 1);
    localparam logic [OSR_LOG2-1:0] PHASE_MID  = OSR_LOG2'((2 ** (OSR_LOG2 - 1)) - 1);
    localparam logic [DIV_W-1:0]    DEF_INT    = DIV_W'(DEF_DIV_INT);
    localparam logic [FRAC_W-1:0]   DEF_FRAC   = FRAC_W'(DEF_DIV_FRAC);

    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic [OSR_LOG2-1:0] phase_q, phase_d;
    logic [DIV_W-1:0]    div_int_q, div_int_d, shd_int_q, shd_int_d;
    logic [FRAC_W-1:0]   div_frac_q, div_frac_d, shd_frac_q, shd_frac_d;
    logic                pend_q, pend_d, err_q, err_d;
    logic                x16_q, x16_d, bit_q, bit_d, mid_q, mid_d;

    logic                cnt_zero, bit_evt, apply;
    logic [DIV_W-1:0]    src_int, div_eff, reload;
    logic [FRAC_W-1:0]   src_frac;
    logic [FRAC_W:0]     acc_sum;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        cnt_zero   = (cnt_q == '0);
        bit_evt    = en_i & cnt_zero & (phase_q == PHASE_LAST);
        apply      = (pend_q | cfg_load_i) & (restart_i | ~en_i | bit_evt);
        src_int    = cfg_load_i ? cfg_div_int_i  : shd_int_q;
        src_frac   = cfg_load_i ? cfg_div_frac_i : shd_frac_q;

        shd_int_d  = cfg_load_i ? cfg_div_int_i  : shd_int_q;
        shd_frac_d = cfg_load_i ? cfg_div_frac_i : shd_frac_q;
        div_int_d  = apply ? src_int  : div_int_q;
        div_frac_d = apply ? src_frac : div_frac_q;
        pend_d     = apply ? 1'b0 : (pend_q | cfg_load_i);
        err_d      = apply ? (src_int == '0) : err_q;

        // A zero integer divisor runs as one cycle per oversample tick.
        div_eff    = (div_int_d == '0) ? DIV_W'(1) : div_int_d;
        reload     = div_eff - DIV_W'(1);
        acc_sum    = {1'b0, acc_q} + {1'b0, div_frac_d};

        cnt_d      = cnt_q - DIV_W'(1);
        acc_d      = acc_q;
        phase_d    = phase_q;
        x16_d      = 1'b0;
        bit_d      = 1'b0;
        mid_d      = 1'b0;

        if (restart_i || !en_i) begin
            cnt_d   = reload;
            acc_d   = '0;
            phase_d = '0;
        end else if (cnt_zero) begin
            cnt_d   = reload + DIV_W'(acc_sum[FRAC_W]);
            acc_d   = acc_sum[FRAC_W-1:0];
            phase_d = phase_q + OSR_LOG2'(1);
            x16_d   = 1'b1;
            bit_d   = (phase_q == PHASE_LAST);
            mid_d   = (phase_q == PHASE_MID);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= DEF_INT - DIV_W'(1);
            acc_q      <= '0;
            phase_q    <= '0;
            div_int_q  <= DEF_INT;
            div_frac_q <= DEF_FRAC;
            shd_int_q  <= DEF_INT;
            shd_frac_q <= DEF_FRAC;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            x16_q      <= 1'b0;
            bit_q      <= 1'b0;
            mid_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            x16_q      <= x16_d;
            bit_q      <= bit_d;
            mid_q      <= mid_d;
        end
    end

    assign clk_enX16_o = x16_q;
    assign clk_en_o    = bit_q;
    assign mid_en_o    = mid_q;
    assign os_phase_o  = phase_q;
    assign cfg_pend_o  = pend_q;
    assign cfg_err_o   = err_q;

endmodule
